// File: rtl/led_bank_arbiter_pkg.sv
// Shared definitions for the LED bank blocks: arbiter state encoding, bank defaults
// and the hold-timer divider helper.
package led_bank_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1,
    ST_GAP  = 2'd2
  } arb_state_t;

  localparam int DEF_NREQ = 4;
  localparam int DEF_LEDS = 8;

  function automatic int tick_div(input int clock_hz, input int tick_hz);
    return clock_hz / tick_hz;
  endfunction

endpackage

// File: rtl/led_bank_arbiter_if.sv
// Producer <-> LED bank arbiter bundle. With LED_DIM_EN defined a 4-bit dim level
// travels from the producer side to the arbiter.
interface led_bank_arbiter_if #(
  parameter int NREQ = 4,
  parameter int LEDS = 8
);
  logic [NREQ-1:0]      req;
  logic [NREQ*LEDS-1:0] pattern;
  logic [NREQ-1:0]      grant;
  logic                 busy;
  logic [LEDS-1:0]      led;
`ifdef LED_DIM_EN
  logic [3:0]           dim;

  modport master (output req, pattern, dim, input grant, busy, led);
  modport slave  (input req, pattern, dim, output grant, busy, led);
`else
  modport master (output req, pattern, input grant, busy, led);
  modport slave  (input req, pattern, output grant, busy, led);
`endif
endinterface

// File: rtl/led_bank_arbiter_tick_gen.sv
// Free-running prescaler: one-cycle tick every CLOCK/TICK_HZ hwclk cycles.
module led_bank_arbiter_tick_gen
  import led_bank_arbiter_pkg::*;
#(
  parameter int CLOCK   = 12000000,
  parameter int TICK_HZ = 1000
) (
  input  logic hwclk,
  input  logic reset,
  output logic o_tick
);
  localparam int TICK_DIV = tick_div(CLOCK, TICK_HZ);
  localparam int CW       = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge hwclk) begin
    if (reset)              r_cnt <= '0;
    else if (r_cnt == LAST) r_cnt <= '0;
    else                    r_cnt <= r_cnt + CW'(1);
  end

  assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/led_bank_arbiter.sv
// Round-robin owner of the shared LED bank with min/max hold time and a one-cycle
// zero-grant gap between owners. Optional PWM dimming under LED_DIM_EN.
module led_bank_arbiter
  import led_bank_arbiter_pkg::*;
#(
  parameter int NREQ           = DEF_NREQ,
  parameter int LEDS           = DEF_LEDS,
  parameter int CLOCK          = 12000000,
  parameter int TICK_HZ        = 1000,
  parameter int MIN_HOLD_TICKS = 250,
  parameter int MAX_HOLD_TICKS = 2000,
  parameter logic [LEDS-1:0] IDLE_PATTERN = '0
) (
  input  logic           hwclk,
  input  logic           reset,
  led_bank_arbiter_if.slave bus
);
  localparam int IW = $clog2(NREQ);
  localparam int HW = $clog2(MAX_HOLD_TICKS + 1);
  localparam logic [HW-1:0] MIN_H = HW'(MIN_HOLD_TICKS);
  localparam logic [HW-1:0] MAX_H = HW'(MAX_HOLD_TICKS);

  arb_state_t      r_state, w_state_nxt;
  logic [IW-1:0]   r_owner, r_rr_ptr, w_winner;
  logic [HW-1:0]   r_hold_cnt;
  logic [NREQ-1:0] r_grant;
  logic            r_busy;
  logic [LEDS-1:0] r_led_q;
  logic            w_tick, w_owner_req, w_others, w_release;

  // Nearest set request after ptr, wrapping; ptr itself is ranked last.
  function automatic logic [IW-1:0] rr_pick(input logic [NREQ-1:0] req,
                                            input logic [IW-1:0] ptr);
    logic [IW-1:0] pick;
    int idx;
    pick = ptr;
    for (int k = NREQ; k >= 1; k--) begin
      idx = (int'(ptr) + k) % NREQ;
      if (req[idx]) pick = IW'(idx);
    end
    return pick;
  endfunction

  function automatic logic [LEDS-1:0] pat_of(input logic [NREQ*LEDS-1:0] pat,
                                             input logic [IW-1:0] idx);
    logic [LEDS-1:0] r;
    r = '0;
    for (int i = 0; i < NREQ; i++)
      if (int'(idx) == i) r = pat[i*LEDS +: LEDS];
    return r;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] idx);
    logic [NREQ-1:0] r;
    r = '0;
    for (int i = 0; i < NREQ; i++)
      if (int'(idx) == i) r[i] = 1'b1;
    return r;
  endfunction

  led_bank_arbiter_tick_gen #(.CLOCK(CLOCK), .TICK_HZ(TICK_HZ)) u_tick (
    .hwclk  (hwclk),
    .reset  (reset),
    .o_tick (w_tick)
  );

  assign w_winner    = rr_pick(bus.req, r_rr_ptr);
  assign w_owner_req = bus.req[r_owner];
  assign w_others    = |(bus.req & ~r_grant);
  assign w_release   = (r_state == ST_OWN) &&
                       ((!w_owner_req && (r_hold_cnt >= MIN_H)) ||
                        ((r_hold_cnt == MAX_H) && w_others));

  always_ff @(posedge hwclk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (|bus.req) w_state_nxt = ST_OWN;
      ST_OWN:  if (w_release) w_state_nxt = ST_GAP;
      ST_GAP:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge hwclk) begin
    if (reset) begin
      r_grant    <= '0;
      r_busy     <= 1'b0;
      r_led_q    <= IDLE_PATTERN;
      r_hold_cnt <= '0;
      r_rr_ptr   <= IW'(NREQ - 1);
      r_owner    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|bus.req) begin
            r_owner    <= w_winner;
            r_grant    <= onehot(w_winner);
            r_busy     <= 1'b1;
            r_led_q    <= pat_of(bus.pattern, w_winner);
            r_hold_cnt <= '0;
          end else begin
            r_led_q <= IDLE_PATTERN;
          end
        end
        ST_OWN: begin
          if (w_release) begin
            r_grant  <= '0;
            r_busy   <= 1'b0;
            r_led_q  <= IDLE_PATTERN;
            r_rr_ptr <= r_owner;
          end else begin
            // A dropped request freezes the last shown pattern.
            if (w_owner_req) r_led_q <= pat_of(bus.pattern, r_owner);
            if (w_tick && (r_hold_cnt != MAX_H)) r_hold_cnt <= r_hold_cnt + HW'(1);
          end
        end
        default: r_led_q <= IDLE_PATTERN;
      endcase
    end
  end

  assign bus.grant = r_grant;
  assign bus.busy  = r_busy;

`ifdef LED_DIM_EN
  logic [3:0] r_pwm_cnt;

  always_ff @(posedge hwclk) begin
    if (reset) r_pwm_cnt <= 4'd0;
    else       r_pwm_cnt <= r_pwm_cnt + 4'd1;
  end

  assign bus.led = r_led_q & {LEDS{r_pwm_cnt < bus.dim}};
`else
  assign bus.led = r_led_q;
`endif

endmodule

// File: tb/tb_led_bank_arbiter.sv
// Bench for led_bank_arbiter: vector table, hand-written ownership sequences and
// randomized traffic scored against a cycle-level reference model.
module tb_led_bank_arbiter;
  localparam int NREQ = 4, LEDS = 8, TICK_DIV = 10, MINH = 3, MAXH = 6;

  logic hwclk = 1'b0;
  logic reset;
  always #5 hwclk = ~hwclk;

  led_bank_arbiter_if #(.NREQ(NREQ), .LEDS(LEDS)) bus ();

  led_bank_arbiter #(
    .NREQ(NREQ), .LEDS(LEDS), .CLOCK(1000), .TICK_HZ(100),
    .MIN_HOLD_TICKS(MINH), .MAX_HOLD_TICKS(MAXH), .IDLE_PATTERN(8'h00)
  ) dut (
    .hwclk (hwclk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0, errors = 0;
  int cyc = 0;

  // Reference model: owner index (-1 = none), gap flag, pointer, hold ticks.
  int m_owner = -1, m_ptr = NREQ - 1, m_hold = 0, m_tcnt = 0, m_pwm = 0, m_ticks = 0;
  bit m_gap = 1'b0;
  logic [7:0] m_ledq = 8'h00;
  logic [3:0] prev_grant = 4'h0;

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [31:0] pat;
    logic [3:0]  eg;
    logic        eb;
    logic [7:0]  el;
  } vec_t;
  vec_t tbl[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] pat_of(input int i);
    logic [31:0] p;
    p = bus.pattern;
    return p[i*LEDS +: LEDS];
  endfunction

  function automatic logic [7:0] dmask();
`ifdef LED_DIM_EN
    return (m_pwm < int'(bus.dim)) ? 8'hFF : 8'h00;
`else
    return 8'hFF;
`endif
  endfunction

  task automatic model_step();
    bit tick, own_req, others;
    if (reset) begin
      m_owner = -1; m_gap = 1'b0; m_ptr = NREQ - 1; m_hold = 0;
      m_tcnt = 0; m_pwm = 0; m_ledq = 8'h00;
    end else begin
      tick = (m_tcnt == TICK_DIV - 1);
      if (tick) m_ticks++;
      if (m_gap) begin
        m_gap = 1'b0;
      end else if (m_owner < 0) begin
        if (bus.req != 4'h0) begin
          for (int k = 1; k <= NREQ; k++) begin
            if (m_owner < 0 && bus.req[(m_ptr + k) % NREQ]) m_owner = (m_ptr + k) % NREQ;
          end
          m_ledq = pat_of(m_owner);
          m_hold = 0;
        end else begin
          m_ledq = 8'h00;
        end
      end else begin
        own_req = bus.req[m_owner];
        others  = (bus.req & ~(4'b0001 << m_owner)) != 4'h0;
        if ((!own_req && m_hold >= MINH) || (m_hold == MAXH && others)) begin
          m_ptr = m_owner; m_owner = -1; m_gap = 1'b1; m_ledq = 8'h00;
        end else begin
          if (own_req) m_ledq = pat_of(m_owner);
          if (tick && m_hold < MAXH) m_hold++;
        end
      end
      m_tcnt = tick ? 0 : m_tcnt + 1;
      m_pwm  = (m_pwm + 1) % 16;
    end
  endtask

  task automatic step();
    logic [3:0] eg;
    @(posedge hwclk);
    model_step();
    #1;
    cyc++;
    eg = (m_owner >= 0) ? 4'(1 << m_owner) : 4'h0;
    check("grant", 32'(bus.grant), 32'(eg));
    check("busy", 32'(bus.busy), 32'(eg != 4'h0));
    check("led", 32'(bus.led), 32'(m_ledq & dmask()));
    check("grant_onehot0", 32'($onehot0(bus.grant)), 32'd1);
    check("grant_gap", 32'(prev_grant != 4'h0 && bus.grant != 4'h0 && prev_grant != bus.grant), 32'd0);
    prev_grant = bus.grant;
  endtask

  task automatic wait_grant(input logic [3:0] exp, input int budget, input string name);
    int n;
    n = 0;
    while (bus.grant !== exp && n < budget) begin
      step();
      n++;
    end
    check(name, 32'(bus.grant), 32'(exp));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.req = 4'h0;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    int t0, tk, cnt, idx;
    bit ok_hold;
    reset = 1'b1;
    bus.req = 4'h0;
    bus.pattern = 32'h0;
`ifdef LED_DIM_EN
    bus.dim = 4'd15;
`endif

    tbl[0] = '{1'b1, 4'hF, 32'h44332211, 4'h0, 1'b0, 8'h00};
    tbl[1] = '{1'b1, 4'hF, 32'h44332211, 4'h0, 1'b0, 8'h00};
    tbl[2] = '{1'b1, 4'hF, 32'h44332211, 4'h0, 1'b0, 8'h00};
    tbl[3] = '{1'b0, 4'hF, 32'h44332211, 4'h1, 1'b1, 8'h11};
    tbl[4] = '{1'b0, 4'hF, 32'h44332211, 4'h1, 1'b1, 8'h11};
    tbl[5] = '{1'b0, 4'h0, 32'h44332299, 4'h1, 1'b1, 8'h11};
    tbl[6] = '{1'b1, 4'h0, 32'h44332299, 4'h0, 1'b0, 8'h00};
    for (int i = 0; i < 7; i++) begin
      reset = tbl[i].rst;
      bus.req = tbl[i].req;
      bus.pattern = tbl[i].pat;
      step();
      check("vec_grant", 32'(bus.grant), 32'(tbl[i].eg));
      check("vec_busy", 32'(bus.busy), 32'(tbl[i].eb));
      check("vec_led", 32'(bus.led), 32'(tbl[i].el & dmask()));
    end

    // Single requester 2, drop after a tick, minimum hold enforced.
    do_reset();
    bus.pattern = 32'h00A50000;
    bus.req = 4'b0100;
    step();
    t0 = cyc;
    check("req2_grant", 32'(bus.grant), 32'h4);
    check("req2_led", 32'(bus.led), 32'(8'hA5 & dmask()));
    repeat (12) step();
    bus.req = 4'h0;
    wait_grant(4'h0, 200, "req2_release");
    check("req2_min_hold", 32'((cyc - t0) >= 2 * TICK_DIV + 1), 32'd1);
    check("gap_led", 32'(bus.led), 32'h0);
    check("gap_busy", 32'(bus.busy), 32'h0);
    step();
    check("idle_after_gap", 32'(bus.grant), 32'h0);

    // Live pattern update.
    bus.pattern = 32'h00010000;
    bus.req = 4'b0100;
    wait_grant(4'h4, 5, "live_grant");
    check("live_led0", 32'(bus.led), 32'(8'h01 & dmask()));
    bus.pattern = 32'h00020000;
    step();
    check("live_led1", 32'(bus.led), 32'(8'h02 & dmask()));
    bus.req = 4'h0;
    wait_grant(4'h0, 200, "live_release");

    // Preemption at maximum hold.
    do_reset();
    bus.pattern = 32'h80000001;
    bus.req = 4'b0001;
    wait_grant(4'h1, 5, "pre_grant0");
    tk = m_ticks;
    bus.req = 4'b1001;
    wait_grant(4'h0, 200, "pre_revoke");
    check("pre_ticks", 32'((m_ticks - tk) >= MAXH && (m_ticks - tk) <= MAXH + 1), 32'd1);
    wait_grant(4'h8, 5, "pre_grant3");
    ok_hold = 1'b1;
    repeat (35) begin
      step();
      if (bus.grant !== 4'h8) ok_hold = 1'b0;
    end
    check("pre_req0_waits", 32'(ok_hold), 32'd1);
    bus.req = 4'b0001;
    wait_grant(4'h0, 200, "pre_rel3");
    wait_grant(4'h1, 5, "pre_regrant0");
    bus.req = 4'h0;
    wait_grant(4'h0, 200, "pre_rel0");

    // Round-robin order with all requesters active.
    do_reset();
    bus.pattern = 32'h44332211;
    bus.req = 4'hF;
    for (int n = 0; n < 5; n++) begin
      cnt = 0;
      while (bus.grant == 4'h0 && cnt < 10) begin
        step();
        cnt++;
      end
      idx = -1;
      for (int k = 0; k < NREQ; k++) if (bus.grant[k]) idx = k;
      check("rr_order", 32'(idx), 32'(n % 4));
      repeat (35) step();
      bus.req = 4'hF & ~bus.grant;
      wait_grant(4'h0, 200, "rr_release");
      bus.req = 4'hF;
    end

`ifdef LED_DIM_EN
    do_reset();
    bus.dim = 4'd4;
    bus.pattern = 32'h000000FF;
    bus.req = 4'b0001;
    wait_grant(4'h1, 5, "dim_grant");
    cnt = 0;
    repeat (16) begin
      step();
      if (bus.led == 8'hFF) cnt++;
    end
    check("dim_duty", 32'(cnt), 32'd4);
    bus.dim = 4'd15;
`endif

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      reset = ($urandom_range(0, 299) == 0);
      for (int b = 0; b < NREQ; b++)
        if ($urandom_range(0, 19) == 0) bus.req[b] = ~bus.req[b];
      if ($urandom_range(0, 3) == 0) bus.pattern = $urandom;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
